video_palout: RTL and testbench

- Downstream stage of the pixel renderer; converts its 4-bit pixel indices and ULAplus side-band signals into final 6-bit colours (G2:R2:B2).
- Holds a 16-entry Evo palette (CPU-loadable) and a 64-entry ULAplus palette behind the standard select/data register pair.
- Inserts border colour and blanking, then feeds the VGA/TV output mux.
- Pipeline is paced by the same pixel strobe the renderer uses.

---
 rtl/video_palout.sv | 101 ++++++++++
 tb/tb_video_palout.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_palout.sv
// Palette/output stage: maps renderer indices through Evo or ULAplus palettes, adds border and blanking.
// Two-stage pipeline on ena_pix; color follows strobe N+1 and is frozen without strobes; CPU writes are never stalled.
module video_palout #(
  parameter logic [5:0] BLANK_COLOR = 6'b000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena_pix,
  input  logic       pix_area,
  input  logic       hblank,
  input  logic       vblank,
  input  logic [3:0] border,
  input  logic [3:0] pixels,
  input  logic [1:0] up_palsel,
  input  logic [2:0] up_paper,
  input  logic [2:0] up_ink,
  input  logic       up_pixel,
  input  logic       pal_wr,
  input  logic [3:0] pal_a,
  input  logic [5:0] pal_d,
  input  logic       up_sel_wr,
  input  logic       up_dat_wr,
  input  logic [7:0] din,
  output logic [7:0] up_dout,
  output logic       up_mode,
  output logic [5:0] color
);

  // Standard ZX colours with index bit 3 acting as bright.
  function automatic logic [5:0] evo_init(input logic [3:0] i);
    return {i[2], i[2] & i[3], i[1], i[1] & i[3], i[0], i[0] & i[3]};
  endfunction

  // GGGRRRBB -> G2:R2:B2, keeping the two top bits of each channel.
  function automatic logic [5:0] conv(input logic [7:0] d);
    return {d[7], d[6], d[4], d[3], d[1], d[0]};
  endfunction

  logic [7:0] sel;
  logic [7:0] upram [64];
  logic [5:0] evo   [16];

  logic       blk;
  logic       use_up;
  logic [5:0] idx6;
  logic [3:0] idx4;

  wire [1:0] grp = sel[7:6];
  wire [5:0] idx = sel[5:0];

  // Data write decodes the select value from before any same-cycle select update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel     <= 8'h00;
      up_mode <= 1'b0;
      for (int i = 0; i < 64; i++) upram[i] <= 8'h00;
    end else begin
      if (up_dat_wr) begin
        if (grp == 2'b00)      upram[idx] <= din;
        else if (grp == 2'b01) up_mode    <= din[0];
      end
      if (up_sel_wr) sel <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) evo[i] <= evo_init(4'(i));
    end else if (pal_wr) begin
      evo[pal_a] <= pal_d;
    end
  end

  always_comb begin
    up_dout = 8'hFF;
    case (grp)
      2'b00:   up_dout = upram[idx];
      2'b01:   up_dout = {7'b0, up_mode};
      default: up_dout = 8'hFF;
    endcase
  end

  // Border stays on the Evo path even in ULAplus mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk    <= 1'b0;
      use_up <= 1'b0;
      idx6   <= 6'd0;
      idx4   <= 4'd0;
      color  <= 6'd0;
    end else if (ena_pix) begin
      blk    <= hblank | vblank;
      use_up <= up_mode & pix_area;
      idx6   <= {up_palsel, ~up_pixel, up_pixel ? up_ink : up_paper};
      idx4   <= pix_area ? pixels : border;
      color  <= blk    ? BLANK_COLOR :
                use_up ? conv(upram[idx6]) : evo[idx4];
    end
  end

endmodule

// File: tb/tb_video_palout.sv
// Directed bench: stimulus pushes expected colours per strobe, a monitor pops and compares after each strobe.
module tb_video_palout;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena_pix, pix_area, hblank, vblank;
  logic [3:0] border, pixels;
  logic [1:0] up_palsel;
  logic [2:0] up_paper, up_ink;
  logic       up_pixel, pal_wr;
  logic [3:0] pal_a;
  logic [5:0] pal_d;
  logic       up_sel_wr, up_dat_wr;
  logic [7:0] din;
  logic [7:0] up_dout;
  logic       up_mode;
  logic [5:0] color;

  int n_cmp = 0;
  int n_err = 0;

  logic [5:0] q_val [$];
  string      q_name [$];
  logic [5:0] prev_val;
  string      prev_name;
  logic       pw_with_strobe;

  always #5 clk = ~clk;

  video_palout #(.BLANK_COLOR(6'b000000)) dut (
    .clk(clk), .rst_n(rst_n), .ena_pix(ena_pix), .pix_area(pix_area),
    .hblank(hblank), .vblank(vblank), .border(border), .pixels(pixels),
    .up_palsel(up_palsel), .up_paper(up_paper), .up_ink(up_ink), .up_pixel(up_pixel),
    .pal_wr(pal_wr), .pal_a(pal_a), .pal_d(pal_d),
    .up_sel_wr(up_sel_wr), .up_dat_wr(up_dat_wr), .din(din),
    .up_dout(up_dout), .up_mode(up_mode), .color(color)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // A strobe outputs what the previous strobe sampled; exp_now is the colour for the inputs applied now.
  task automatic strobe(input logic [5:0] exp_now, input string nm);
    q_val.push_back(prev_val);
    q_name.push_back(prev_name);
    prev_val  = exp_now;
    prev_name = nm;
    @(negedge clk);
    ena_pix = 1'b1;
    pal_wr  = pw_with_strobe;
    @(negedge clk);
    ena_pix = 1'b0;
    pal_wr  = 1'b0;
    pw_with_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_sel(input logic [7:0] d);
    @(negedge clk); din = d; up_sel_wr = 1'b1;
    @(negedge clk); up_sel_wr = 1'b0;
  endtask

  task automatic cpu_dat(input logic [7:0] d);
    @(negedge clk); din = d; up_dat_wr = 1'b1;
    @(negedge clk); up_dat_wr = 1'b0;
  endtask

  task automatic evo_wr(input logic [3:0] a, input logic [5:0] d);
    @(negedge clk); pal_a = a; pal_d = d; pal_wr = 1'b1;
    @(negedge clk); pal_wr = 1'b0;
  endtask

  always @(posedge clk) begin
    if (rst_n && ena_pix) begin
      @(negedge clk);
      n_cmp++;
      if (q_val.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got %b expected no output", color);
      end else begin
        logic [5:0] v;
        string      nm;
        v  = q_val.pop_front();
        nm = q_name.pop_front();
        if (color !== v) begin
          n_err++;
          $display("FAIL %s: color %b expected %b", nm, color, v);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ena_pix = 0; pix_area = 0; hblank = 0; vblank = 0;
    border = 0; pixels = 0; up_palsel = 0; up_paper = 0; up_ink = 0; up_pixel = 0;
    pal_wr = 0; pal_a = 0; pal_d = 0; up_sel_wr = 0; up_dat_wr = 0; din = 0;
    pw_with_strobe = 1'b0;
    prev_val = 6'd0; prev_name = "restart_after_reset";
    repeat (3) @(negedge clk);
    check("reset_color", {2'b0, color}, 8'h00);
    check("reset_up_mode", {7'b0, up_mode}, 8'h00);
    check("reset_up_dout", up_dout, 8'h00);
    rst_n = 1'b1;

    // Evo path with default palette
    pix_area = 1; pixels = 4'hF;
    strobe(6'b111111, "evo_F");
    pixels = 4'h2;
    strobe(6'b001000, "evo_2");
    strobe(6'b001000, "evo_2_hold");

    // Evo write, border, blanking
    evo_wr(4'd5, 6'b010101);
    pix_area = 0; border = 4'd5;
    strobe(6'b010101, "border_5");
    vblank = 1;
    strobe(6'b000000, "vblank");
    vblank = 0; hblank = 1;
    strobe(6'b000000, "hblank");
    hblank = 0;

    // ULAplus registers
    cpu_sel(8'h40);
    cpu_dat(8'h01);
    check("up_mode_on", {7'b0, up_mode}, 8'h01);
    check("up_dout_mode", up_dout, 8'h01);
    cpu_sel(8'h1B);
    cpu_dat(8'hE3);
    check("up_dout_1B", up_dout, 8'hE3);
    cpu_sel(8'h80);
    check("up_dout_grp2", up_dout, 8'hFF);

    // ULAplus pixel path, and border still through Evo
    pix_area = 1; up_palsel = 2'd1; up_pixel = 0; up_paper = 3'd3; up_ink = 3'd3;
    strobe(6'b110011, "up_paper");
    up_pixel = 1;
    strobe(6'b000000, "up_ink");
    pix_area = 0; border = 4'd5;
    strobe(6'b010101, "up_border_evo");

    // Same-cycle select and data write: data lands at the old index
    cpu_sel(8'h1B);
    @(negedge clk); din = 8'h05; up_sel_wr = 1; up_dat_wr = 1;
    @(negedge clk); up_sel_wr = 0; up_dat_wr = 0;
    check("collide_new_idx", up_dout, 8'h00);
    cpu_sel(8'h1B);
    check("collide_old_idx", up_dout, 8'h05);

    // Palette write coinciding with the strobe reading that entry
    pal_a = 4'd5; pal_d = 6'b111000; pw_with_strobe = 1'b1;
    strobe(6'b111000, "pal_wr_new");
    strobe(6'b111000, "pal_wr_hold");

    // Drive 3F then reset asynchronously mid-cycle
    border = 4'hF;
    strobe(6'b111111, "pre_reset_F");
    strobe(6'b111111, "pre_reset_F2");
    check("pre_reset_color", {2'b0, color}, 8'h3F);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset_color", {2'b0, color}, 8'h00);
    check("async_reset_up_mode", {7'b0, up_mode}, 8'h00);
    prev_val = 6'd0; prev_name = "restart_after_reset";
    @(negedge clk); rst_n = 1'b1;
    cpu_sel(8'h1B);
    check("reset_upram_1B", up_dout, 8'h00);
    cpu_sel(8'h80);
    cpu_dat(8'h01);
    cpu_sel(8'h40);
    check("grp2_write_ignored", up_dout, 8'h00);

    // Evo defaults restored
    pix_area = 1; pixels = 4'd9;
    strobe(6'b000011, "evo_9");
    pixels = 4'd5;
    strobe(6'b100010, "evo_5_default");
    strobe(6'b100010, "evo_5_hold");

    // No strobes: output frozen despite input and palette changes
    pixels = 4'hF;
    evo_wr(4'd5, 6'b000001);
    repeat (10) @(negedge clk);
    check("freeze", {2'b0, color}, 8'h22);

    for (int i = 0; i < 100 && q_val.size() != 0; i++) @(negedge clk);
    if (q_val.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain: %0d outputs pending expected 0", q_val.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
